mc10141_shift_ctl: RTL and testbench

//  Sequencer directly upstream of a chain of mc10141 universal shift register slices.

---
 rtl/mc10141_shift_ctl_if.sv | 32 +++
 rtl/mc10141_shift_ctl.sv | 139 +++++++++++++
 tb/tb_mc10141_shift_ctl.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/mc10141_shift_ctl_if.sv
// Request and chain-control bundle between a shift requester and the mc10141 chain sequencer.
// The master side issues requests and owns the chain; the slave side is the sequencer.
interface mc10141_shift_ctl_if #(
    parameter int unsigned CNT_W = 6
) ();
    logic             req_valid;
    logic             req_ready;
    logic             req_load;
    logic             req_dir;
    logic [1:0]       req_kind;
    logic [CNT_W-1:0] req_count;
    logic             chain_q_first;
    logic             chain_q_last;
    logic             op2;
    logic             op1;
    logic             shft0in;
    logic             shft3in;
    logic             busy;
    logic             done;

    modport master (
        output req_valid, req_load, req_dir, req_kind, req_count,
        output chain_q_first, chain_q_last,
        input  req_ready, op2, op1, shft0in, shft3in, busy, done
    );

    modport slave (
        input  req_valid, req_load, req_dir, req_kind, req_count,
        input  chain_q_first, chain_q_last,
        output req_ready, op2, op1, shft0in, shft3in, busy, done
    );
endinterface

// File: rtl/mc10141_shift_ctl.sv
// Sequencer for a chain of mc10141 shift register slices: optional parallel load,
// then a counted run of single-bit shifts with programmable end fill, then a done pulse.
module mc10141_shift_ctl #(
    parameter int unsigned CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mc10141_shift_ctl_if.slave   bus
);
    localparam logic [1:0] MODE_LOAD = 2'b00;
    localparam logic [1:0] MODE_SHL  = 2'b01;
    localparam logic [1:0] MODE_SHR  = 2'b10;
    localparam logic [1:0] MODE_HOLD = 2'b11;

    localparam logic [1:0] KIND_ZERO  = 2'd0;
    localparam logic [1:0] KIND_ONES  = 2'd1;
    localparam logic [1:0] KIND_ARITH = 2'd2;
    localparam logic [1:0] KIND_ROT   = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t           state;
    logic [1:0]       mode;
    logic             ready_q;
    logic             busy_q;
    logic             done_q;
    logic             dir_q;
    logic [1:0]       kind_q;
    logic [CNT_W-1:0] rem;
    logic             fill0;
    logic             fill3;

    // Sequencer: mode lines and status are registered alongside the state so the
    // chain never sees a combinational path from the request inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            mode    <= MODE_HOLD;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dir_q   <= 1'b0;
            kind_q  <= KIND_ZERO;
            rem     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid && ready_q) begin
                        dir_q   <= bus.req_dir;
                        kind_q  <= bus.req_kind;
                        rem     <= bus.req_count;
                        busy_q  <= 1'b1;
                        ready_q <= 1'b0;
                        if (bus.req_load) begin
                            state <= LOAD;
                            mode  <= MODE_LOAD;
                        end else if (bus.req_count != '0) begin
                            state <= SHIFT;
                            mode  <= bus.req_dir ? MODE_SHR : MODE_SHL;
                        end else begin
                            state  <= FIN;
                            mode   <= MODE_HOLD;
                            done_q <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (rem != '0) begin
                        state <= SHIFT;
                        mode  <= dir_q ? MODE_SHR : MODE_SHL;
                    end else begin
                        state  <= FIN;
                        mode   <= MODE_HOLD;
                        done_q <= 1'b1;
                    end
                end
                SHIFT: begin
                    rem <= rem - CNT_W'(1);
                    if (rem == CNT_W'(1)) begin
                        state  <= FIN;
                        mode   <= MODE_HOLD;
                        done_q <= 1'b1;
                    end
                end
                FIN: begin
                    state   <= IDLE;
                    mode    <= MODE_HOLD;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: begin
                    state   <= IDLE;
                    mode    <= MODE_HOLD;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    // End fill bits: live only while shifting, sampled by the chain on the step edge.
    always_comb begin
        fill0 = 1'b0;
        fill3 = 1'b0;
        if (state == SHIFT) begin
            if (!dir_q) begin
                case (kind_q)
                    KIND_ZERO:  fill0 = 1'b0;
                    KIND_ONES:  fill0 = 1'b1;
                    KIND_ARITH: fill0 = bus.chain_q_first;
                    KIND_ROT:   fill0 = bus.chain_q_last;
                    default:    fill0 = 1'b0;
                endcase
            end else begin
                case (kind_q)
                    KIND_ZERO:  fill3 = 1'b0;
                    KIND_ONES:  fill3 = 1'b1;
                    KIND_ARITH: fill3 = 1'b0;
                    KIND_ROT:   fill3 = bus.chain_q_first;
                    default:    fill3 = 1'b0;
                endcase
            end
        end
    end

    assign bus.op2       = mode[1];
    assign bus.op1       = mode[0];
    assign bus.shft0in   = fill0;
    assign bus.shft3in   = fill3;
    assign bus.req_ready = ready_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_mc10141_shift_ctl.sv
// Bench for mc10141_shift_ctl driving a behavioural 36-bit chain of nine mc10141 slices.
module tb_mc10141_shift_ctl;
    localparam int unsigned CNT_W = 6;
    localparam int NV = 15;

    typedef struct {
        logic        load;
        logic        dir;
        logic [1:0]  kind;
        logic [5:0]  count;
        logic [35:0] d;
        logic [35:0] exp_chain;
        int          exp_busy;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [35:0] chain;
    logic [35:0] chain_d;
    int          total;
    int          bad;
    vec_t        vecs [NV];

    mc10141_shift_ctl_if #(.CNT_W(CNT_W)) bus ();

    mc10141_shift_ctl #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Chain model: bit 0 (first q0) is the MSB of 'chain', last q3 is the LSB.
    assign bus.chain_q_first = chain[35];
    assign bus.chain_q_last  = chain[0];

    always_ff @(posedge clk) begin
        case ({bus.op2, bus.op1})
            2'b00:   chain <= chain_d;
            2'b01:   chain <= {bus.shft0in, chain[35:1]};
            2'b10:   chain <= {chain[34:0], bus.shft3in};
            default: chain <= chain;
        endcase
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic exp_fill0(input logic [1:0] kind, input logic [35:0] c);
        case (kind)
            2'd1:    return 1'b1;
            2'd2:    return c[35];
            2'd3:    return c[0];
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic exp_fill3(input logic [1:0] kind, input logic [35:0] c);
        case (kind)
            2'd1:    return 1'b1;
            2'd3:    return c[35];
            default: return 1'b0;
        endcase
    endfunction

    // Issue one request and follow it cycle by cycle until busy drops.
    task automatic run_req(input vec_t v, output int bc, output int dc, output int se);
        int g;
        int n;
        logic [1:0] em;
        logic sh, e0, e3, ed;
        bc = 0; dc = 0; se = 0; g = 0;
        n = int'(v.load) + int'(v.count);
        while (bus.req_ready !== 1'b1 && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (g >= 100) se++;
        bus.req_valid = 1'b1;
        bus.req_load  = v.load;
        bus.req_dir   = v.dir;
        bus.req_kind  = v.kind;
        bus.req_count = v.count;
        chain_d       = v.d;
        @(negedge clk);
        bus.req_valid = 1'b0;
        while (bus.busy === 1'b1 && bc < 100) begin
            if (v.load && bc == 0)  em = 2'b00;
            else if (bc < n)        em = v.dir ? 2'b10 : 2'b01;
            else                    em = 2'b11;
            sh = (em == 2'b01) || (em == 2'b10);
            e0 = (sh && !v.dir) ? exp_fill0(v.kind, chain) : 1'b0;
            e3 = (sh &&  v.dir) ? exp_fill3(v.kind, chain) : 1'b0;
            ed = (bc == n);
            if ({bus.op2, bus.op1} !== em || bus.shft0in !== e0 || bus.shft3in !== e3 ||
                bus.done !== ed || bus.req_ready !== 1'b0)
                se++;
            if (bus.done === 1'b1) dc++;
            bc++;
            @(negedge clk);
        end
    endtask

    initial begin
        int bc, dc, se, g, rl_err, dn;
        total = 0;
        bad   = 0;
        //          load  dir   kind  cnt    d              exp_chain      busy
        vecs[0]  = '{1'b1, 1'b0, 2'd0, 6'd0,  36'h123456789, 36'h123456789, 2};
        vecs[1]  = '{1'b1, 1'b0, 2'd0, 6'd0,  36'h800000000, 36'h800000000, 2};
        vecs[2]  = '{1'b0, 1'b0, 2'd2, 6'd3,  36'h0,         36'hF00000000, 4};
        vecs[3]  = '{1'b1, 1'b0, 2'd0, 6'd0,  36'h800000001, 36'h800000001, 2};
        vecs[4]  = '{1'b0, 1'b1, 2'd3, 6'd4,  36'h0,         36'h000000018, 5};
        vecs[5]  = '{1'b1, 1'b0, 2'd0, 6'd0,  36'h0,         36'h000000000, 2};
        vecs[6]  = '{1'b0, 1'b0, 2'd1, 6'd63, 36'h0,         36'hFFFFFFFFF, 64};
        vecs[7]  = '{1'b1, 1'b1, 2'd0, 6'd4,  36'h0F0F0F0F0, 36'hF0F0F0F00, 6};
        vecs[8]  = '{1'b0, 1'b0, 2'd0, 6'd8,  36'h0,         36'h00F0F0F0F, 9};
        vecs[9]  = '{1'b0, 1'b0, 2'd3, 6'd4,  36'h0,         36'hF00F0F0F0, 5};
        vecs[10] = '{1'b0, 1'b1, 2'd1, 6'd4,  36'h0,         36'h00F0F0F0F, 5};
        vecs[11] = '{1'b0, 1'b1, 2'd2, 6'd1,  36'h0,         36'h01E1E1E1E, 2};
        vecs[12] = '{1'b1, 1'b0, 2'd0, 6'd0,  36'hA00000005, 36'hA00000005, 2};
        vecs[13] = '{1'b0, 1'b0, 2'd2, 6'd2,  36'h0,         36'hE80000001, 3};
        vecs[14] = '{1'b0, 1'b0, 2'd1, 6'd0,  36'h0,         36'hE80000001, 1};

        bus.req_valid = 1'b0;
        bus.req_load  = 1'b0;
        bus.req_dir   = 1'b0;
        bus.req_kind  = 2'd0;
        bus.req_count = '0;
        chain_d       = '0;
        rst_n         = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ops",   64'({bus.op2, bus.op1}), 64'(2'b11));
        check("rst_fill",  64'({bus.shft0in, bus.shft3in}), 64'(2'b00));
        check("rst_busy",  64'(bus.busy), 64'(0));
        check("rst_done",  64'(bus.done), 64'(0));
        check("rst_ready", 64'(bus.req_ready), 64'(1));
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            run_req(vecs[i], bc, dc, se);
            check($sformatf("v%0d_chain", i), 64'(chain), 64'(vecs[i].exp_chain));
            check($sformatf("v%0d_busy", i),  64'(bc), 64'(vecs[i].exp_busy));
            check($sformatf("v%0d_done", i),  64'(dc), 64'(1));
            check($sformatf("v%0d_seq", i),   64'(se), 64'(0));
        end

        // Back-to-back with req_valid held high: second accept only after the idle cycle.
        bus.req_valid = 1'b1;
        bus.req_load  = 1'b0;
        bus.req_dir   = 1'b1;
        bus.req_kind  = 2'd1;
        bus.req_count = 6'd2;
        @(negedge clk);
        g = 0; rl_err = 0;
        while (bus.done !== 1'b1 && g < 20) begin
            if (bus.req_ready !== 1'b0) rl_err++;
            @(negedge clk);
            g++;
        end
        check("b2b_done_seen", 64'(g < 20), 64'(1));
        check("b2b_fin_ready", 64'(bus.req_ready), 64'(0));
        check("b2b_rdy_low",   64'(rl_err), 64'(0));
        @(negedge clk);
        check("b2b_idle_ready", 64'(bus.req_ready), 64'(1));
        check("b2b_idle_busy",  64'(bus.busy), 64'(0));
        @(negedge clk);
        check("b2b_second_accept", 64'(bus.busy), 64'(1));
        bus.req_valid = 1'b0;
        g = 0;
        while (bus.busy === 1'b1 && g < 20) begin
            @(negedge clk);
            g++;
        end
        check("b2b_end", 64'(g < 20), 64'(1));
        check("b2b_chain", 64'(chain), 64'(36'h80000001F));

        // Reset in the middle of a 10-step run leaves the 3-step result in the chain.
        run_req('{1'b1, 1'b0, 2'd0, 6'd0, 36'h000000001, 36'h000000001, 2}, bc, dc, se);
        check("pre_rst_chain", 64'(chain), 64'(36'h000000001));
        bus.req_valid = 1'b1;
        bus.req_load  = 1'b0;
        bus.req_dir   = 1'b1;
        bus.req_kind  = 2'd0;
        bus.req_count = 6'd10;
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ops",   64'({bus.op2, bus.op1}), 64'(2'b11));
        check("mid_rst_busy",  64'(bus.busy), 64'(0));
        check("mid_rst_fill",  64'(bus.shft3in), 64'(0));
        check("mid_rst_ready", 64'(bus.req_ready), 64'(1));
        dn = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (bus.done !== 1'b0) dn++;
        end
        check("mid_rst_no_done", 64'(dn), 64'(0));
        check("mid_rst_chain",   64'(chain), 64'(36'h000000008));
        rst_n = 1'b1;
        @(negedge clk);
        run_req('{1'b0, 1'b1, 2'd0, 6'd1, 36'h0, 36'h000000010, 2}, bc, dc, se);
        check("post_rst_chain", 64'(chain), 64'(36'h000000010));
        check("post_rst_busy",  64'(bc), 64'(2));
        check("post_rst_seq",   64'(se), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
